// File: rtl/adc_scan_sequencer_pkg.sv
// adc_scan_sequencer shared definitions:
// FSM encoding, ADC channel address width and packed-bus slice helper.
`ifndef ADC_SCAN_SEQUENCER_PKG_SV
`define ADC_SCAN_SEQUENCER_PKG_SV

`define ADC_CH_SLICE(i) [(i)*DATA_W +: DATA_W]

package adc_scan_sequencer_pkg;

  localparam int CH_ADDR_W = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEEK  = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SEEK  = ST_SEEK,
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_STORE = ST_STORE
  } state_t;

endpackage

`endif

// File: rtl/adc_scan_sequencer_avg_accum.sv
// adc_avg_accum: sums 2^AVG_LOG2 samples; width DATA_W+AVG_LOG2
// so an all-ones burst averages back to all-ones.
module adc_avg_accum #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic              last_o,
  output logic [DATA_W-1:0] avg_o
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (add) begin
      acc_q <= acc_q + ACC_W'(din);
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // high while the next accepted sample completes the burst
  assign last_o = (cnt_q == LAST);
  assign avg_o  = acc_q[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks enabled ADC channels, oversamples each,
// publishes averaged results with valid flags and a stall watchdog.
module adc_scan_sequencer
  import adc_scan_sequencer_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic                     continuous,
  input  logic                     start,
  output logic                     sample_req,
  output logic [CH_ADDR_W-1:0]     ch_addr,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        sample_data,
  output logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_valid,
  output logic                     scan_done,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IDX_W = $clog2(N_CH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(N_CH);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t                  state_q;
  logic [N_CH-1:0]         mask_q;
  logic [IDX_W-1:0]        idx_q;
  logic [WD_W-1:0]         wd_q;
  logic [WD_W-1:0]         wd_d;
  logic                    sample_req_q;
  logic [CH_ADDR_W-1:0]    ch_addr_q;
  logic [N_CH*DATA_W-1:0]  ch_data_q;
  logic [N_CH-1:0]         ch_valid_q;
  logic                    scan_done_q;
  logic                    timeout_err_q;

  logic              acc_add;
  logic              acc_clr;
  logic              acc_last;
  logic              wd_expire;
  logic [DATA_W-1:0] acc_avg;

  assign wd_d      = wd_q + 1'b1;
  assign wd_expire = !sample_valid && (wd_d == WD_LAST);
  assign acc_add   = (state_q == S_WAIT) && sample_valid;
  assign acc_clr   = (state_q == S_STORE) ||
                     ((state_q == S_WAIT) && wd_expire);

  adc_avg_accum #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .add    (acc_add),
    .din    (sample_data),
    .last_o (acc_last),
    .avg_o  (acc_avg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      idx_q         <= '0;
      wd_q          <= '0;
      sample_req_q  <= 1'b0;
      ch_addr_q     <= '0;
      ch_data_q     <= '0;
      ch_valid_q    <= '0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sample_req_q <= 1'b0;
      scan_done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            timeout_err_q <= 1'b0;
            mask_q        <= ch_enable;
            idx_q         <= '0;
            if (ch_enable == '0) scan_done_q <= 1'b1;
            else state_q <= S_SEEK;
          end
        end
        S_SEEK: begin
          if (idx_q == IDX_END) begin
            scan_done_q <= 1'b1;
            if (continuous) begin
              mask_q <= ch_enable;
              idx_q  <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (mask_q[idx_q]) begin
            ch_addr_q    <= CH_ADDR_W'(idx_q);
            sample_req_q <= 1'b1;
            state_q      <= S_REQ;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_REQ: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // a sample landing on the expiry cycle still counts
          if (sample_valid) begin
            if (acc_last) begin
              state_q <= S_STORE;
            end else begin
              sample_req_q <= 1'b1;
              state_q      <= S_REQ;
            end
          end else if (wd_expire) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wd_q <= wd_d;
          end
        end
        S_STORE: begin
          ch_data_q `ADC_CH_SLICE(int'(idx_q)) <= acc_avg;
          ch_valid_q[idx_q] <= 1'b1;
          idx_q   <= idx_q + 1'b1;
          state_q <= S_SEEK;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sample_req  = sample_req_q;
  assign ch_addr     = ch_addr_q;
  assign ch_data     = ch_data_q;
  assign ch_valid    = ch_valid_q;
  assign scan_done   = scan_done_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Parametrised channel scanner between an I2C ADC controller and the per-channel scaler/bin2bcd chains.
- Walks an enable-masked set of N_CH channels, issues one conversion request per sample, and oversamples each channel by 2^AVG_LOG2.
- Publishes a packed bus of averaged results with per-channel valid flags.
- Supports continuous and single-shot scans, with a watchdog on a stalled ADC.

Parameters:
N_CH, 4, number of channels scanned (1..16)
DATA_W, 12, raw sample width
AVG_LOG2, 2, log2 of samples averaged per channel (0..6)
TIMEOUT_CYC, 200000, clk cycles to wait for sample_valid before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ch_enable  in  N_CH  channel mask, sampled at scan start
continuous  in  1  1 = rescan forever; 0 = single-shot
start  in  1  pulse, begins a scan when idle
sample_req  out  1  one-cycle pulse requesting a conversion on ch_addr
ch_addr  out  4  channel address to the ADC config byte
sample_valid  in  1  one-cycle pulse, sample_data valid
sample_data  in  DATA_W  raw conversion result
ch_data  out  N_CH*DATA_W  averaged results; channel i at [i*DATA_W +: DATA_W]
ch_valid  out  N_CH  bit i set once channel i holds a result
scan_done  out  1  one-cycle pulse at end of each full scan
busy  out  1  high whenever the state is not IDLE
timeout_err  out  1  sticky; set on watchdog expiry, cleared by start or rst

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including ch_data, ch_valid and ch_addr. Accumulator, sample counter and watchdog are 0.
- FSM states: IDLE, SEEK, REQ, WAIT, STORE.
- IDLE: on start=1, latch mask = ch_enable, set idx=0, clear timeout_err, go to SEEK. If the latched mask is all zero, pulse scan_done next cycle and return to IDLE.
- SEEK: if mask[idx]=1, drive ch_addr=idx and go to REQ. Otherwise idx++; when idx passes N_CH-1, go to STORE-end handling (scan end).
- REQ: sample_req=1 for exactly one cycle. Watchdog loads 0. Go to WAIT.
- WAIT: the watchdog increments each cycle.
  - On sample_valid: acc += sample_data, and cnt++.
    - If cnt reaches 2^AVG_LOG2, go to STORE.
    - Otherwise return to REQ.
  - If the watchdog reaches TIMEOUT_CYC-1 without sample_valid: set timeout_err, discard the accumulator, leave ch_valid[idx] unchanged, go to IDLE. No scan_done.
- STORE:
  - Write ch_data[idx] = acc >> AVG_LOG2 (truncating), set ch_valid[idx]=1, clear acc and cnt.
  - Advance idx to the next channel, then go to SEEK.
- Scan end (idx wraps past N_CH-1):
  - Pulse scan_done for one cycle.
  - If continuous=1, re-latch the mask from ch_enable and restart at idx=0 without returning to IDLE.
  - Otherwise go to IDLE.
- Accumulator width: DATA_W+AVG_LOG2. It must never overflow, so all-ones samples average back to all-ones.
- sample_valid outside WAIT is ignored. sample_valid in the same cycle as watchdog expiry: the sample wins and no timeout is raised.
- start while busy is ignored. Deasserting continuous mid-scan finishes the current scan, then goes to IDLE.
- ch_enable changes mid-scan take effect only at the next scan start.
- ch_data/ch_valid for unscanned channels hold their previous values. Only rst clears ch_valid.
- rst mid-scan: everything returns to reset values in the next cycle. An in-flight sample_valid after rst is ignored.
- Latency, AVG_LOG2=0, single enabled channel, ADC response k cycles after sample_req:
  - ch_data updates 2 cycles after sample_valid (WAIT→STORE register write).
  - scan_done follows 1 cycle later.

Decomposition:
- Shared header: state encoding localparams.
- Shared header: an ADC_CH_SLICE(i) macro giving the packed-bus slice [i*DATA_W +: DATA_W]. This macro replaces per-design wire-array merge macros.
- Shared header: the ch_addr width of 4 bits.
- One natural sub-module: adc_avg_accum. It holds acc, cnt, the done flag and the shifted result, with inputs clr, add and din. The FSM, watchdog and output registers stay in the top.

Test Plan:
- N_CH=4, AVG_LOG2=2, mask 4'b1111, single-shot; ADC model returns ch*1000+{0,1,2,3} → ch_data = {3001,2001,1001,1} (truncated mean), ch_valid=4'b1111, one scan_done, sample_req count 16.
- Mask 4'b1010 → ch_addr sequence 1,1,1,1,3,3,3,3. ch_valid=4'b1010. Channels 0 and 2 remain 0.
- All samples 12'hFFF with AVG_LOG2=6 → result 12'hFFF (no overflow). Mask 0 with start → scan_done one cycle later, zero sample_req.
- ADC model silent on channel 2, TIMEOUT_CYC=50 → timeout_err=1 exactly 50 cycles after the REQ. busy drops. ch_valid[2] unchanged. No scan_done. The next start clears timeout_err.
- continuous=1 for 3 scans, then drop continuous → exactly 3 or 4 scan_done pulses (the scan in progress completes), then IDLE. Toggling ch_enable mid-scan affects only the next scan.
- rst asserted during WAIT with sample_valid in the following cycle → all outputs 0, state IDLE, sample ignored.
